// File: rtl/axi_master_sram.sv
// ============================================================================
// Module      : axi_master_sram
// Description : Single-outstanding AXI master bridging pulse-request load/store
//               requests onto 64-bit AXI read and write channels.
//               Optional feature macro: AXI_MASTER_SRAM_ALIGN_EN (sub-word
//               alignment of address, strobe and data lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_master_sram (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        WREQ,
    input  logic [63:0] IN_WADDR,
    input  logic [63:0] IN_WDATA,
    input  logic [7:0]  IN_WMASK,
    input  logic        RREQ,
    input  logic [63:0] IN_RADDR,
    output logic [63:0] DATA_OUT,
    output logic [63:0] AW_ADDR,
    output logic        AW_VALID,
    input  logic        AW_READY,
    output logic [63:0] W_DATA,
    output logic [7:0]  W_STRB,
    output logic        W_VALID,
    input  logic        W_READY,
    input  logic        B_VALID,
    output logic        B_READY,
    output logic [63:0] AR_ADDR,
    output logic        AR_VALID,
    input  logic        AR_READY,
    input  logic [63:0] R_DATA,
    input  logic        R_VALID,
    output logic        R_READY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_AR   = 3'd1,
        S_RD_R    = 3'd2,
        S_WR_AW_W = 3'd3,
        S_WR_B    = 3'd4
    } state_t;

    state_t      r_state;
    logic [63:0] r_aw_addr;
    logic        r_aw_valid;
    logic [63:0] r_w_data;
    logic [7:0]  r_w_strb;
    logic        r_w_valid;
    logic        r_b_ready;
    logic [63:0] r_ar_addr;
    logic        r_ar_valid;
    logic        r_r_ready;
    logic [63:0] r_data_out;

    logic [63:0] w_wr_addr;
    logic [63:0] w_wr_data;
    logic [7:0]  w_wr_strb;
    logic [63:0] w_rd_addr;
    logic [63:0] w_rd_data;
    logic        w_r_fire;
    logic        w_aw_done;
    logic        w_w_done;

`ifdef AXI_MASTER_SRAM_ALIGN_EN
    // Byte offset of the outstanding read, needed to shift the returned beat.
    logic [2:0]  r_roff;

    assign w_wr_addr = {IN_WADDR[63:3], 3'b000};
    assign w_wr_data = IN_WDATA << {IN_WADDR[2:0], 3'b000};
    assign w_wr_strb = IN_WMASK << IN_WADDR[2:0];
    assign w_rd_addr = {IN_RADDR[63:3], 3'b000};
    assign w_rd_data = R_DATA >> {r_roff, 3'b000};

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_roff <= 3'd0;
        end else if (r_state == S_IDLE && !WREQ && RREQ) begin
            r_roff <= IN_RADDR[2:0];
        end
    end
`else
    assign w_wr_addr = IN_WADDR;
    assign w_wr_data = IN_WDATA;
    assign w_wr_strb = IN_WMASK;
    assign w_rd_addr = IN_RADDR;
    assign w_rd_data = R_DATA;
`endif

    assign w_r_fire  = r_r_ready & R_VALID;
    // A channel counts as done once its handshake has happened or happens now.
    assign w_aw_done = ~r_aw_valid | AW_READY;
    assign w_w_done  = ~r_w_valid  | W_READY;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= S_IDLE;
            r_aw_addr  <= 64'd0;
            r_aw_valid <= 1'b0;
            r_w_data   <= 64'd0;
            r_w_strb   <= 8'd0;
            r_w_valid  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_ar_addr  <= 64'd0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_data_out <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (WREQ) begin
                        r_aw_addr  <= w_wr_addr;
                        r_w_data   <= w_wr_data;
                        r_w_strb   <= w_wr_strb;
                        r_aw_valid <= 1'b1;
                        r_w_valid  <= 1'b1;
                        r_state    <= S_WR_AW_W;
                    end else if (RREQ) begin
                        r_ar_addr  <= w_rd_addr;
                        r_ar_valid <= 1'b1;
                        r_state    <= S_RD_AR;
                    end
                end
                S_RD_AR: begin
                    if (AR_READY) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (w_r_fire) begin
                        r_data_out <= w_rd_data;
                        r_r_ready  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_WR_AW_W: begin
                    if (AW_READY) begin
                        r_aw_valid <= 1'b0;
                    end
                    if (W_READY) begin
                        r_w_valid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_b_ready <= 1'b1;
                        r_state   <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (B_VALID) begin
                        r_b_ready <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_aw_valid <= 1'b0;
                    r_w_valid  <= 1'b0;
                    r_b_ready  <= 1'b0;
                    r_ar_valid <= 1'b0;
                    r_r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign AW_ADDR  = r_aw_addr;
    assign AW_VALID = r_aw_valid;
    assign W_DATA   = r_w_data;
    assign W_STRB   = r_w_strb;
    assign W_VALID  = r_w_valid;
    assign B_READY  = r_b_ready;
    assign AR_ADDR  = r_ar_addr;
    assign AR_VALID = r_ar_valid;
    assign R_READY  = r_r_ready;
    // Read data bypasses the register during the handshake cycle.
    assign DATA_OUT = w_r_fire ? w_rd_data : r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_axi_master_sram.sv
// ============================================================================
// Module      : tb_axi_master_sram
// Description : Self-checking bench for axi_master_sram with randomized
//               transactions checked against a behavioural lane model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_master_sram;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        WREQ = 1'b0;
    logic [63:0] IN_WADDR = '0;
    logic [63:0] IN_WDATA = '0;
    logic [7:0]  IN_WMASK = '0;
    logic        RREQ = 1'b0;
    logic [63:0] IN_RADDR = '0;
    logic [63:0] DATA_OUT;
    logic [63:0] AW_ADDR;
    logic        AW_VALID;
    logic        AW_READY = 1'b0;
    logic [63:0] W_DATA;
    logic [7:0]  W_STRB;
    logic        W_VALID;
    logic        W_READY = 1'b0;
    logic        B_VALID = 1'b0;
    logic        B_READY;
    logic [63:0] AR_ADDR;
    logic        AR_VALID;
    logic        AR_READY = 1'b0;
    logic [63:0] R_DATA = '0;
    logic        R_VALID = 1'b0;
    logic        R_READY;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [63:0] last_rd = '0;

    axi_master_sram dut (
        .CLK(CLK), .RESETN(RESETN),
        .WREQ(WREQ), .IN_WADDR(IN_WADDR), .IN_WDATA(IN_WDATA), .IN_WMASK(IN_WMASK),
        .RREQ(RREQ), .IN_RADDR(IN_RADDR), .DATA_OUT(DATA_OUT),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    always #5 CLK = ~CLK;

    // Reference lane model: what the slave should see and the user should get.
    function automatic logic [63:0] m_addr(input logic [63:0] a);
`ifdef AXI_MASTER_SRAM_ALIGN_EN
        return a - (a % 64'd8);
`else
        return a;
`endif
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [63:0] a);
`ifdef AXI_MASTER_SRAM_ALIGN_EN
        return d << (8 * (a % 64'd8));
`else
        return d;
`endif
    endfunction

    function automatic logic [7:0] m_strb(input logic [7:0] m, input logic [63:0] a);
        logic [15:0] t;
`ifdef AXI_MASTER_SRAM_ALIGN_EN
        t = {8'd0, m} << (a % 64'd8);
`else
        t = {8'd0, m};
`endif
        return t[7:0];
    endfunction

    function automatic logic [63:0] m_rdata(input logic [63:0] r, input logic [63:0] a);
`ifdef AXI_MASTER_SRAM_ALIGN_EN
        return r >> (8 * (a % 64'd8));
`else
        return r;
`endif
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Read transaction starting from IDLE, with slave delays on AR and R.
    task automatic do_read(input logic [63:0] addr, input logic [63:0] rdata,
                           input int ar_dly, input int r_dly);
        logic [63:0] exp_d;
        exp_d = m_rdata(rdata, addr);
        RREQ = 1'b1; IN_RADDR = addr;
        step();
        RREQ = 1'b0; IN_RADDR = {$urandom, $urandom};
        for (int c = 0; c <= ar_dly; c++) begin
            AR_READY = (c == ar_dly);
            #1;
            total_cnt++;
            if (AR_VALID !== 1'b1 || AR_ADDR !== m_addr(addr) || R_READY !== 1'b0)
                $display("FAIL rd_ar c=%0d: valid=%b addr=%h rready=%b, need valid=1 addr=%h rready=0",
                         c, AR_VALID, AR_ADDR, R_READY, m_addr(addr));
            else pass_cnt++;
            @(posedge CLK); #1;
        end
        AR_READY = 1'b0;
        for (int c = 0; c < r_dly; c++) begin
            R_DATA = {$urandom, $urandom};
            #1;
            total_cnt++;
            if (R_READY !== 1'b1 || AR_VALID !== 1'b0 || DATA_OUT !== last_rd)
                $display("FAIL rd_wait c=%0d: rready=%b arvalid=%b data=%h, need 1/0/%h",
                         c, R_READY, AR_VALID, DATA_OUT, last_rd);
            else pass_cnt++;
            @(posedge CLK); #1;
        end
        R_VALID = 1'b1; R_DATA = rdata;
        #1;
        total_cnt++;
        if (R_READY !== 1'b1 || DATA_OUT !== exp_d)
            $display("FAIL rd_hs: rready=%b data=%h, need rready=1 data=%h", R_READY, DATA_OUT, exp_d);
        else pass_cnt++;
        @(posedge CLK); #1;
        R_VALID = 1'b0; R_DATA = {$urandom, $urandom};
        last_rd = exp_d;
        #1;
        total_cnt++;
        if (R_READY !== 1'b0 || AR_VALID !== 1'b0 || DATA_OUT !== exp_d)
            $display("FAIL rd_done: rready=%b arvalid=%b data=%h, need 0/0/%h",
                     R_READY, AR_VALID, DATA_OUT, exp_d);
        else pass_cnt++;
    endtask

    // Write body after the request edge: AW/W with independent delays, then B.
    task automatic write_body(input logic [63:0] addr, input logic [63:0] data,
                              input logic [7:0] mask, input int aw_dly,
                              input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        for (int c = 0; c < 16 && !(aw_done && w_done); c++) begin
            AW_READY = (c >= aw_dly);
            W_READY  = (c >= w_dly);
            #1;
            total_cnt++;
            if (AW_VALID !== !aw_done || W_VALID !== !w_done || B_READY !== 1'b0 || AR_VALID !== 1'b0)
                $display("FAIL wr_valid c=%0d: awv=%b wv=%b bready=%b arv=%b, need %b/%b/0/0",
                         c, AW_VALID, W_VALID, B_READY, AR_VALID, !aw_done, !w_done);
            else pass_cnt++;
            if (!aw_done) begin
                total_cnt++;
                if (AW_ADDR !== m_addr(addr))
                    $display("FAIL wr_addr: got %h need %h", AW_ADDR, m_addr(addr));
                else pass_cnt++;
            end
            if (!w_done) begin
                total_cnt++;
                if (W_DATA !== m_wdata(data, addr) || W_STRB !== m_strb(mask, addr))
                    $display("FAIL wr_data: got %h/%h need %h/%h",
                             W_DATA, W_STRB, m_wdata(data, addr), m_strb(mask, addr));
                else pass_cnt++;
            end
            @(posedge CLK); #1;
            if (AW_READY) aw_done = 1;
            if (W_READY)  w_done  = 1;
        end
        AW_READY = 1'b0; W_READY = 1'b0;
        for (int c = 0; c < b_dly; c++) begin
            #1;
            total_cnt++;
            if (B_READY !== 1'b1 || AW_VALID !== 1'b0 || W_VALID !== 1'b0)
                $display("FAIL wr_bwait c=%0d: bready=%b awv=%b wv=%b, need 1/0/0",
                         c, B_READY, AW_VALID, W_VALID);
            else pass_cnt++;
            @(posedge CLK); #1;
        end
        B_VALID = 1'b1;
        #1;
        total_cnt++;
        if (B_READY !== 1'b1)
            $display("FAIL wr_bhs: bready=%b need 1", B_READY);
        else pass_cnt++;
        @(posedge CLK); #1;
        B_VALID = 1'b0;
        #1;
        total_cnt++;
        if (B_READY !== 1'b0 || AW_VALID !== 1'b0 || W_VALID !== 1'b0 || DATA_OUT !== last_rd)
            $display("FAIL wr_done: bready=%b awv=%b wv=%b data=%h, need 0/0/0/%h",
                     B_READY, AW_VALID, W_VALID, DATA_OUT, last_rd);
        else pass_cnt++;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] mask, input int aw_dly,
                            input int w_dly, input int b_dly);
        WREQ = 1'b1; IN_WADDR = addr; IN_WDATA = data; IN_WMASK = mask;
        step();
        WREQ = 1'b0; IN_WADDR = {$urandom, $urandom}; IN_WDATA = {$urandom, $urandom};
        IN_WMASK = 8'($urandom);
        write_body(addr, data, mask, aw_dly, w_dly, b_dly);
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        step(); step();
        total_cnt++;
        if (AW_VALID !== 0 || W_VALID !== 0 || B_READY !== 0 || AR_VALID !== 0 || R_READY !== 0 ||
            AW_ADDR !== 0 || AR_ADDR !== 0 || W_DATA !== 0 || W_STRB !== 0 || DATA_OUT !== 0)
            $display("FAIL reset_state: awv=%b wv=%b br=%b arv=%b rr=%b aw=%h ar=%h wd=%h ws=%h do=%h, need all 0",
                     AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, AW_ADDR, AR_ADDR, W_DATA, W_STRB, DATA_OUT);
        else pass_cnt++;
        RESETN = 1'b1;
        step();
        // Complete one read, then abort a second one while R_READY is high.
        do_read(64'h0000_0000_8000_0010, 64'hDEAD_BEEF_0BAD_F00D, 0, 0);
        RREQ = 1'b1; IN_RADDR = 64'h0000_0000_8000_0020;
        step();
        RREQ = 1'b0; AR_READY = 1'b1;
        step();
        AR_READY = 1'b0;
        #1;
        total_cnt++;
        if (R_READY !== 1'b1)
            $display("FAIL reset_pre: rready=%b need 1", R_READY);
        else pass_cnt++;
        #1 RESETN = 1'b0;
        #1;
        total_cnt++;
        if (R_READY !== 0 || AR_VALID !== 0 || AR_ADDR !== 0 || DATA_OUT !== 0)
            $display("FAIL reset_async: rready=%b arv=%b ar=%h data=%h, need all 0",
                     R_READY, AR_VALID, AR_ADDR, DATA_OUT);
        else pass_cnt++;
        R_VALID = 1'b1; R_DATA = 64'h1234_5678_9ABC_DEF0;
        step(); step();
        RESETN = 1'b1;
        step(); step();
        total_cnt++;
        if (R_READY !== 0 || DATA_OUT !== 0 || AR_VALID !== 0)
            $display("FAIL reset_stale_r: rready=%b data=%h arv=%b, need 0/0/0", R_READY, DATA_OUT, AR_VALID);
        else pass_cnt++;
        R_VALID = 1'b0;
        last_rd = '0;
        step();
    endtask

    task automatic test_read();
        do_read(64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 0, 0);
        do_read(64'h0000_0000_8000_0003, 64'h1122_3344_5566_7788, 0, 0);
        for (int i = 0; i < 10; i++)
            do_read({$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic test_write();
        do_write(64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 8'h01, 3, 0, 1);
        for (int i = 0; i < 10; i++)
            do_write({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                     $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
    endtask

    task automatic test_backpressure();
        do_read(64'h0000_0000_8000_0100, {$urandom, $urandom}, 2, 5);
        do_read({$urandom, $urandom}, {$urandom, $urandom}, 0, 7);
    endtask

    task automatic test_collision();
        logic [63:0] wa;
        logic [63:0] wd;
        wa = {$urandom, $urandom};
        wd = {$urandom, $urandom};
        WREQ = 1'b1; IN_WADDR = wa; IN_WDATA = wd; IN_WMASK = 8'hF0;
        RREQ = 1'b1; IN_RADDR = {$urandom, $urandom};
        step();
        WREQ = 1'b0;
        // RREQ stays high for a busy cycle and must be dropped.
        #1;
        total_cnt++;
        if (AR_VALID !== 1'b0 || AW_VALID !== 1'b1)
            $display("FAIL collide_sel: arv=%b awv=%b, need 0/1", AR_VALID, AW_VALID);
        else pass_cnt++;
        step();
        RREQ = 1'b0;
        write_body(wa, wd, 8'hF0, 1, 2, 2);
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt++;
            if (AR_VALID !== 1'b0 || AW_VALID !== 1'b0)
                $display("FAIL collide_idle c=%0d: arv=%b awv=%b, need 0/0", c, AR_VALID, AW_VALID);
            else pass_cnt++;
        end
        // Read in flight: a write pulse during RD_R must be ignored.
        RREQ = 1'b1; IN_RADDR = 64'h0000_0000_8000_0040;
        step();
        RREQ = 1'b0; AR_READY = 1'b1;
        step();
        AR_READY = 1'b0; WREQ = 1'b1; IN_WADDR = {$urandom, $urandom};
        step();
        WREQ = 1'b0;
        #1;
        total_cnt++;
        if (AW_VALID !== 1'b0 || W_VALID !== 1'b0 || R_READY !== 1'b1)
            $display("FAIL collide_busy_w: awv=%b wv=%b rr=%b, need 0/0/1", AW_VALID, W_VALID, R_READY);
        else pass_cnt++;
        R_VALID = 1'b1; R_DATA = 64'hA5A5_5A5A_0F0F_F0F0;
        step();
        R_VALID = 1'b0;
        last_rd = m_rdata(64'hA5A5_5A5A_0F0F_F0F0, 64'h0000_0000_8000_0040);
        step();
        total_cnt++;
        if (DATA_OUT !== last_rd || AW_VALID !== 1'b0 || R_READY !== 1'b0)
            $display("FAIL collide_rd_done: data=%h awv=%b rr=%b, need %h/0/0",
                     DATA_OUT, AW_VALID, R_READY, last_rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_read({$urandom, $urandom}, {$urandom, $urandom}, 0, $urandom_range(0, 2));
            else
                do_write({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                         $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_collision();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
